chatbot_timer_sched: RTL and testbench
======================================

// Module: chatbot_timer_sched
// PURPOSE
//  Avalon-MM write-master that owns the SOC interval timer: programs period/control after reset,
//  services its IRQ (status clear) and turns each timeout into a 1-cycle tick. Shares that single
//  hardware tick among NUM_CH independent one-shot countdown channels used by the chatbot datapath.
//  Sits between fabric-side requesters and the timer's s1 slave port (no waitrequest, 1-cycle writes).
// PARAMETERS
//  NUM_CH       4      number of countdown channels (1..16)
//  CNT_W        16     width of each channel's tick count
//  TICK_CYCLES  50000  clk cycles per tick after reset (timer period reg = TICK_CYCLES-1)
// PORTS
//  clk            in   1             system clock; single clock domain
//  reset          in   1             asynchronous, active-high reset
//  tmr_address    out  3             timer register address (0 status,1 control,2 period_l,3 period_h)
//  tmr_chipselect out  1             timer chipselect, registered
//  tmr_write_n    out  1             timer write strobe, active low, registered
//  tmr_writedata  out  16            timer write data, registered
//  tmr_irq        in   1             timer IRQ, level, held until status is written
//  cfg_period     in   32            new tick period in clk cycles
//  cfg_load       in   1             1-cycle pulse: reprogram timer with cfg_period
//  running        out  1             timer programmed and ticking (FSM in RUN/ACK)
//  tick           out  1             1-cycle pulse per serviced timeout
//  arm            in   NUM_CH        per-channel start pulse
//  arm_ticks      in   NUM_CH*CNT_W  per-channel count, channel i at [i*CNT_W +: CNT_W]
//  cancel         in   NUM_CH        per-channel abort pulse
//  busy           out  NUM_CH        channel counting
//  expire         out  NUM_CH        1-cycle pulse when channel count reaches zero
// BEHAVIOUR
//  Reset: tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, running=0, tick=0,
//   busy=0, expire=0, pend_period=TICK_CYCLES, pend flag clear. FSM enters STOP on the first edge after release.
//  All timer-bus outputs registered; one write per cycle, chipselect=1/write_n=0 only in write states.
//  FSM (one write each, in order):
//   STOP  : addr1 data 0x0008 (STOP)
//   PER_L : addr2 data P[15:0]    (P = pend_period-1)
//   PER_H : addr3 data P[31:16]
//   CLR   : addr0 data 0x0000    (drop stale timeout)
//   START : addr1 data 0x0007    (ITO|CONT|START) -> RUN
//   RUN   : bus idle; tmr_irq=1 -> ACK; else pend flag set -> STOP
//   ACK   : addr0 data 0x0000; tick=1 this cycle; -> RUN (irq is low by next cycle)
//  cfg_load: latch pend_period=max(cfg_period,2) and set pend flag in any state; flag cleared on
//   entering STOP. A load arriving mid-sequence is applied after the current sequence reaches RUN.
//  irq and pend both set in RUN: ACK first, then reprogram.
//  running=1 in RUN/ACK only; no ticks generated during reprogramming.
//  Channel i (registered count c, busy b), priority per cycle:
//   1. arm[i]: n=arm_ticks slice; n==0 -> expire[i]=1 next cycle, b=0; else c=n, b=1 (restart if busy)
//   2. cancel[i]: b=0, no expire
//   3. tick & b: c==1 -> c=0, b=0, expire[i]=1 next cycle; else c=c-1
//  arm beats cancel and tick in the same cycle; expire is a pure pulse, never held.
//  Channel state holds across reprogramming; reset mid-operation clears everything, bus goes idle.
// STRUCTURE
//  Package chatbot_timer_pkg: register addresses (ADDR_STATUS..ADDR_PERIOD_H), control bits
//   (CTL_ITO=0, CTL_CONT=1, CTL_START=2, CTL_STOP=3), FSM state enum.
//  Sub-module chatbot_tick_chan: one channel (arm/cancel/tick -> busy/expire), generated NUM_CH times.
//  Top: FSM + bus register + pending-config register.
// TESTING (bench uses a behavioural timer model with irq after P+1 cycles)
//  1. Release reset -> writes (1,0x0008),(2,0xC34F),(3,0x0000),(0,0x0000),(1,0x0007) on 5 consecutive cycles; running=1.
//  2. Model raises irq -> exactly one write (0,0x0000) next cycle, tick=1 for 1 cycle, irq drops.
//  3. arm[0] ticks=3 -> expire[0] one cycle after the 3rd tick; busy[0] high between arm and expire.
//  4. arm[1] ticks=0 -> expire[1] next cycle, busy[1] never high; arm[2]+cancel[2] same cycle -> armed.
//  5. cfg_load period=100 while ch3 has count 5 -> writes 0x0008,0x0063,0x0000,0x0000,0x0007; ch3 still 5.
//  6. Assert reset during PER_H write -> all outputs at reset values, full sequence restarts on release.

Source files
------------

// File: rtl/chatbot_timer_sched_pkg.sv
// Shared definitions for the chatbot interval-timer scheduler: timer register map,
// control-register bit positions, sequencer states and the period clamp.
package chatbot_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam logic [15:0] CTL_STOP_WORD = 16'd1 << CTL_STOP;
  localparam logic [15:0] CTL_RUN_WORD  = (16'd1 << CTL_ITO) | (16'd1 << CTL_CONT) | (16'd1 << CTL_START);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_STOP,
    ST_PER_L,
    ST_PER_H,
    ST_CLR,
    ST_START,
    ST_RUN,
    ST_ACK
  } tmr_state_e;

  // A period below two cycles cannot be serviced by the RUN/ACK loop.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

endpackage

// File: rtl/chatbot_timer_sched_if.sv
// Avalon-MM write bus to the interval timer's s1 slave plus its IRQ line.
interface chatbot_timer_sched_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/chatbot_timer_sched_tick_chan.sv
// One one-shot countdown channel driven by the shared timer tick.
module chatbot_tick_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [CNT_W-1:0] arm_ticks,
  input  logic             cancel,
  input  logic             tick,
  output logic             busy,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             expire_q, expire_d;

  // Next-state: arm overrides cancel, cancel overrides a tick.
  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    expire_d = 1'b0;
    if (arm) begin
      if (arm_ticks == {CNT_W{1'b0}}) begin
        busy_d   = 1'b0;
        expire_d = 1'b1;
      end else begin
        cnt_d  = arm_ticks;
        busy_d = 1'b1;
      end
    end else if (cancel) begin
      busy_d = 1'b0;
    end else if (tick && busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d    = {CNT_W{1'b0}};
        busy_d   = 1'b0;
        expire_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
    end
  end

  assign busy   = busy_q;
  assign expire = expire_q;

endmodule

// File: rtl/chatbot_timer_sched.sv
// Interval-timer owner: programs and services the SOC timer over Avalon-MM and
// fans the resulting tick out to NUM_CH one-shot countdown channels.
module chatbot_timer_sched
  import chatbot_timer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int TICK_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  chatbot_timer_sched_if.master   tmr,
  input  logic [31:0]             cfg_period,
  input  logic                    cfg_load,
  output logic                    running,
  output logic                    tick,
  input  logic [NUM_CH-1:0]       arm,
  input  logic [NUM_CH*CNT_W-1:0] arm_ticks,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expire
);

  tmr_state_e  state_q, state_d;
  logic [31:0] pend_period_q, pend_period_d;
  logic        pend_q, pend_d;
  logic [31:0] prog_period_q, prog_period_d;
  logic [2:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [15:0] wdata_q, wdata_d;
  logic        running_q, running_d;
  logic        tick_q, tick_d;
  logic        enter_stop_s;
  logic [31:0] p_s;

  // Sequencer next state and pending-configuration bookkeeping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_STOP;
      ST_STOP:  state_d = ST_PER_L;
      ST_PER_L: state_d = ST_PER_H;
      ST_PER_H: state_d = ST_CLR;
      ST_CLR:   state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (tmr.tmr_irq) begin
          state_d = ST_ACK;
        end else if (pend_q) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ACK:   state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase

    enter_stop_s = (state_d == ST_STOP) && (state_q != ST_STOP);

    pend_period_d = pend_period_q;
    pend_d        = pend_q;
    if (cfg_load) begin
      pend_period_d = clamp_period(cfg_period);
      pend_d        = 1'b1;
    end else if (enter_stop_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    // Snapshot the period once per sequence so a mid-sequence load cannot split halves.
    if (enter_stop_s) begin
      prog_period_d = pend_period_q;
    end else begin
      prog_period_d = prog_period_q;
    end
  end

  assign p_s = prog_period_q - 32'd1;

  // Bus and status registers are loaded from the upcoming state so they line up with it.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = ADDR_STATUS;
    wdata_d = 16'h0000;
    case (state_d)
      ST_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTL_STOP_WORD;
      end
      ST_PER_L: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wdata_d = p_s[15:0];
      end
      ST_PER_H: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wdata_d = p_s[31:16];
      end
      ST_CLR, ST_ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;   wdata_d = 16'h0000;
      end
      ST_START: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTL_RUN_WORD;
      end
      default: begin
        cs_d = 1'b0; wn_d = 1'b1; addr_d = ADDR_STATUS;   wdata_d = 16'h0000;
      end
    endcase
    running_d = (state_d == ST_RUN) || (state_d == ST_ACK);
    tick_d    = (state_d == ST_ACK);
  end

  // Sequencer, configuration and bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      pend_period_q <= 32'(TICK_CYCLES);
      pend_q        <= 1'b0;
      prog_period_q <= 32'(TICK_CYCLES);
      addr_q        <= 3'd0;
      cs_q          <= 1'b0;
      wn_q          <= 1'b1;
      wdata_q       <= 16'h0000;
      running_q     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_period_q <= pend_period_d;
      pend_q        <= pend_d;
      prog_period_q <= prog_period_d;
      addr_q        <= addr_d;
      cs_q          <= cs_d;
      wn_q          <= wn_d;
      wdata_q       <= wdata_d;
      running_q     <= running_d;
      tick_q        <= tick_d;
    end
  end

  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = wn_q;
  assign tmr.tmr_writedata  = wdata_q;
  assign running            = running_q;
  assign tick               = tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    chatbot_tick_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .arm       (arm[g]),
      .arm_ticks (arm_ticks[g*CNT_W +: CNT_W]),
      .cancel    (cancel[g]),
      .tick      (tick_q),
      .busy      (busy[g]),
      .expire    (expire[g])
    );
  end

endmodule

// File: tb/tb_chatbot_timer_sched.sv
// Bench for chatbot_timer_sched: behavioural interval-timer slave, countdown
// reference model, per-cycle compare process and directed scenario checks.
module tb_chatbot_timer_sched;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [31:0]             cfg_period;
  logic                    cfg_load;
  logic                    running, tick;
  logic [NUM_CH-1:0]       arm, cancel, busy, expire;
  logic [NUM_CH*CNT_W-1:0] arm_ticks;

  int vectors = 0;
  int miscompares = 0;

  chatbot_timer_sched_if bus ();

  chatbot_timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_CYCLES(50000)) dut (
    .clk(clk), .reset(reset), .tmr(bus), .cfg_period(cfg_period), .cfg_load(cfg_load),
    .running(running), .tick(tick), .arm(arm), .arm_ticks(arm_ticks), .cancel(cancel),
    .busy(busy), .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interval timer slave: writes program it, irq fires P+1 cycles after start and on each reload.
  logic [31:0] t_per, t_cnt;
  logic        t_run;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.tmr_irq <= 1'b0; t_per <= 32'd0; t_cnt <= 32'd0; t_run <= 1'b0;
    end else begin
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd0) bus.tmr_irq <= 1'b0;
      else if (t_run && t_cnt == 32'd0) bus.tmr_irq <= 1'b1;
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd1) begin
        if (bus.tmr_writedata[3]) t_run <= 1'b0;
        else if (bus.tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
      end else if (t_run) begin
        t_cnt <= (t_cnt == 32'd0) ? t_per : t_cnt - 32'd1;
      end
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd2) t_per[15:0]  <= bus.tmr_writedata;
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd3) t_per[31:16] <= bus.tmr_writedata;
    end
  end

  // Countdown reference: remaining tick count per channel, consumed by each observed tick.
  int          m_left [NUM_CH];
  logic [NUM_CH-1:0] m_busy, m_exp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= '0; m_exp <= '0;
      for (int i = 0; i < NUM_CH; i++) m_left[i] <= 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (arm[i]) begin
          m_left[i] <= int'(arm_ticks[i*CNT_W +: CNT_W]);
          m_busy[i] <= (arm_ticks[i*CNT_W +: CNT_W] != 16'd0);
          m_exp[i]  <= (arm_ticks[i*CNT_W +: CNT_W] == 16'd0);
        end else if (cancel[i]) begin
          m_busy[i] <= 1'b0; m_exp[i] <= 1'b0;
        end else if (tick && m_busy[i]) begin
          m_left[i] <= m_left[i] - 1;
          m_busy[i] <= (m_left[i] > 1);
          m_exp[i]  <= (m_left[i] == 1);
        end else begin
          m_exp[i] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model and the bus rules.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("expire", 32'(expire), 32'(m_exp));
      chk("strobe_pair", 32'(bus.tmr_chipselect), 32'(!bus.tmr_write_n));
      chk("tick_is_ack", 32'(tick),
          32'(bus.tmr_chipselect && bus.tmr_address == 3'd0 && running));
      if (bus.tmr_chipselect && running)
        chk("ack_data", 32'({bus.tmr_address, bus.tmr_writedata}), 32'd0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"}, 32'(bus.tmr_chipselect), 32'd0);
    chk({tag, "_wn"}, 32'(bus.tmr_write_n), 32'd1);
    chk({tag, "_addr"}, 32'(bus.tmr_address), 32'd0);
    chk({tag, "_data"}, 32'(bus.tmr_writedata), 32'd0);
    chk({tag, "_run_tick"}, 32'({running, tick}), 32'd0);
    chk({tag, "_busy_exp"}, 32'({busy, expire}), 32'd0);
  endtask

  task automatic chk_write(input string name, input logic [2:0] a, input logic [15:0] d);
    chk({name, "_cs"}, 32'(bus.tmr_chipselect), 32'd1);
    chk({name, "_wd"}, 32'({bus.tmr_address, bus.tmr_writedata}), 32'({a, d}));
  endtask

  task automatic expect_prog(input string tag, input logic [15:0] pl, input logic [15:0] ph);
    @(negedge clk); chk_write({tag, "_stop"}, 3'd1, 16'h0008);
    chk({tag, "_notrun"}, 32'(running), 32'd0);
    @(negedge clk); chk_write({tag, "_perl"}, 3'd2, pl);
    @(negedge clk); chk_write({tag, "_perh"}, 3'd3, ph);
    @(negedge clk); chk_write({tag, "_clr"}, 3'd0, 16'h0000);
    @(negedge clk); chk_write({tag, "_start"}, 3'd1, 16'h0007);
    @(negedge clk);
    chk({tag, "_running"}, 32'(running), 32'd1);
    chk({tag, "_idle"}, 32'(bus.tmr_chipselect), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int ticks_seen;
    int rec [NUM_CH];
    reset = 1'b1; cfg_period = 32'd0; cfg_load = 1'b0;
    arm = '0; cancel = '0; arm_ticks = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Power-up programming with the default 50000-cycle period.
    expect_prog("boot", 16'hC34F, 16'h0000);

    // First timeout is acknowledged with one status write and a single tick.
    budget = 0;
    while (!bus.tmr_irq && budget < 60000) begin @(negedge clk); budget++; end
    chk("irq_seen", 32'(bus.tmr_irq), 32'd1);
    chk("pre_ack_idle", 32'(bus.tmr_chipselect), 32'd0);
    @(negedge clk);
    chk_write("ack", 3'd0, 16'h0000);
    chk("ack_tick", 32'(tick), 32'd1);
    @(negedge clk);
    chk("post_ack", 32'({bus.tmr_chipselect, tick, bus.tmr_irq, running}), 32'b0001);

    // Channel 3 holds a count of 5 across reprogramming to a 100-cycle period.
    arm = 4'b1000; arm_ticks = {16'd5, 16'd0, 16'd0, 16'd0};
    @(negedge clk); arm = '0;
    cfg_period = 32'd100; cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
    chk("load_gap", 32'(bus.tmr_chipselect), 32'd0);
    expect_prog("reprog", 16'h0063, 16'h0000);
    chk("ch3_held", 32'(busy[3]), 32'd1);

    // Same cycle: ch0 armed with 3, ch1 armed with 0, ch2 armed with 2 while cancelled.
    arm = 4'b0111; cancel = 4'b0100; arm_ticks = {16'd0, 16'd2, 16'd0, 16'd3};
    @(negedge clk); arm = '0; cancel = '0;
    chk("ch1_zero_expire", 32'(expire[1]), 32'd1);
    chk("arm_busy", 32'(busy), 32'b1101);
    ticks_seen = 0;
    for (int i = 0; i < NUM_CH; i++) rec[i] = -1;
    budget = 0;
    while (rec[3] < 0 && budget < 1500) begin
      @(negedge clk); budget++;
      chk("ch1_never_busy", 32'(busy[1]), 32'd0);
      for (int i = 0; i < NUM_CH; i++) if (expire[i] && rec[i] < 0) rec[i] = ticks_seen;
      if (tick) ticks_seen++;
    end
    chk("ch0_after_3", 32'(rec[0]), 32'd3);
    chk("ch2_after_2", 32'(rec[2]), 32'd2);
    chk("ch3_after_5", 32'(rec[3]), 32'd5);

    // Cancel stops a running count without an expire pulse.
    arm = 4'b0010; arm_ticks = {16'd0, 16'd0, 16'd10, 16'd0};
    @(negedge clk); arm = '0;
    chk("ch1_armed", 32'(busy[1]), 32'd1);
    cancel = 4'b0010;
    @(negedge clk); cancel = '0;
    chk("ch1_cancelled", 32'({busy[1], expire[1]}), 32'd0);

    // Period below two clamps to 2 (P=1); reset lands during the PER_H write.
    arm = 4'b0001; arm_ticks = {16'd0, 16'd0, 16'd0, 16'd50};
    @(negedge clk); arm = '0;
    cfg_period = 32'd1; cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
    budget = 0;
    while (!(bus.tmr_chipselect && bus.tmr_address == 3'd1 && !running) && budget < 300) begin
      @(negedge clk); budget++;
    end
    chk_write("clamp_stop", 3'd1, 16'h0008);
    @(negedge clk); chk_write("clamp_perl", 3'd2, 16'h0001);
    @(negedge clk); chk_write("clamp_perh", 3'd3, 16'h0000);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_prog("restart", 16'hC34F, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
